sm_regview_ctrl: RTL

//  Sequencer for the sm_top debug register-read port (regAddr/regData) on the board top.

---
 rtl/sm_regview_if.sv | 27 ++
 rtl/sm_regview_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sm_regview_if.sv
// Bundle of the register-view controller's board-facing signals: control inputs,
// the sm_top register-read port and the display outputs.
interface sm_regview_if #(
   parameter int ADDR_W = 5
);
   logic              mode_auto;
   logic              step;
   logic [ADDR_W-1:0] manAddr;
   logic [ADDR_W-1:0] addrLo;
   logic [ADDR_W-1:0] addrHi;
   logic [31:0]       regData;
   logic [ADDR_W-1:0] regAddr;
   logic [ADDR_W-1:0] dispAddr;
   logic [1:0]        bytePage;
   logic [7:0]        dispByte;
   logic              valid;

   modport master (
      input  mode_auto, step, manAddr, addrLo, addrHi, regData,
      output regAddr, dispAddr, bytePage, dispByte, valid
   );

   modport slave (
      output mode_auto, step, manAddr, addrLo, addrHi, regData,
      input  regAddr, dispAddr, bytePage, dispByte, valid
   );
endinterface

// File: rtl/sm_regview_ctrl.sv
// Sequences reads of the sm_top debug register port and pages the captured 32-bit
// value onto the two hex digits one byte at a time, in manual or auto-scan mode.
module sm_regview_ctrl #(
   parameter int ADDR_W       = 5,
   parameter int DWELL_CYCLES = 25000000
) (
   input  logic         clkIn,
   input  logic         rst_n,
   sm_regview_if.master rv_if
);

   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_CAPT  = 2'd2,
      S_DWELL = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] regAddr_q, regAddr_d;
   logic [ADDR_W-1:0] dispAddr_q, dispAddr_d;
   logic [1:0]        page_q, page_d;
   logic [31:0]       shadow_q, shadow_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stepPrev_q;
   logic              modePrev_q;

   logic              stepRise;
   logic              modeChg;
   logic              expiry;
   logic [ADDR_W-1:0] startAddr;
   logic [ADDR_W-1:0] nextAddr;

   assign stepRise  = rv_if.step & ~stepPrev_q;
   assign modeChg   = rv_if.mode_auto ^ modePrev_q;
   assign expiry    = (cnt_q == CNT_LAST);
   assign startAddr = rv_if.mode_auto ? rv_if.addrLo : rv_if.manAddr;

   // An inverted range, or a current address pushed out of range by a live edit, restarts at addrLo.
   always_comb begin
      if ((rv_if.addrLo > rv_if.addrHi) || (regAddr_q < rv_if.addrLo) ||
          (regAddr_q >= rv_if.addrHi)) begin
         nextAddr = rv_if.addrLo;
      end else begin
         nextAddr = regAddr_q + ADDR_ONE;
      end
   end

   always_comb begin
      state_d    = state_q;
      regAddr_d  = regAddr_q;
      dispAddr_d = dispAddr_q;
      page_d     = page_q;
      shadow_d   = shadow_q;
      valid_d    = 1'b0;
      cnt_d      = cnt_q;

      if (modeChg) begin
         page_d    = 2'd0;
         regAddr_d = startAddr;
         state_d   = S_ADDR;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               regAddr_d = startAddr;
               state_d   = S_ADDR;
            end
            S_ADDR: begin
               state_d = S_CAPT;
            end
            S_CAPT: begin
               shadow_d   = rv_if.regData;
               dispAddr_d = regAddr_q;
               valid_d    = 1'b1;
               cnt_d      = '0;
               state_d    = S_DWELL;
            end
            S_DWELL: begin
               // Counter parks on its last value; every expiry branch below leaves or restarts it.
               if (!expiry) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (!rv_if.mode_auto) begin
                  if (rv_if.manAddr != regAddr_q) begin
                     regAddr_d = rv_if.manAddr;
                     page_d    = 2'd0;
                     state_d   = S_ADDR;
                  end else if (stepRise) begin
                     page_d = page_q + 2'd1;
                     cnt_d  = '0;
                  end else if (expiry) begin
                     state_d = S_ADDR;
                  end
               end else if (stepRise || expiry) begin
                  if (page_q != 2'd3) begin
                     page_d = page_q + 2'd1;
                     cnt_d  = '0;
                  end else begin
                     page_d    = 2'd0;
                     regAddr_d = nextAddr;
                     state_d   = S_ADDR;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clkIn) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         regAddr_q  <= '0;
         dispAddr_q <= '0;
         page_q     <= 2'd0;
         shadow_q   <= 32'd0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         stepPrev_q <= 1'b0;
         modePrev_q <= rv_if.mode_auto;
      end else begin
         state_q    <= state_d;
         regAddr_q  <= regAddr_d;
         dispAddr_q <= dispAddr_d;
         page_q     <= page_d;
         shadow_q   <= shadow_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         stepPrev_q <= rv_if.step;
         modePrev_q <= rv_if.mode_auto;
      end
   end

   assign rv_if.regAddr  = regAddr_q;
   assign rv_if.dispAddr = dispAddr_q;
   assign rv_if.bytePage = page_q;
   assign rv_if.dispByte = shadow_q[{page_q, 3'b000} +: 8];
   assign rv_if.valid    = valid_q;

endmodule
